// File: rtl/sipo_capture_pkg.sv
// Shared types and defaults for the serial frame capture block.
// The PARITY state is only reachable when PARITY_CHECK_EN is defined.
package sipo_capture_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int                      DEF_SYNC_LEN     = 4;
    localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC_PATTERN = 4'b1011;
    localparam int                      FRAME_CNT_W      = 4;

endpackage

// File: rtl/sipo_sync_detect.sv
// Sliding-window sync detector. The window shifts one bit per enabled
// cycle and match_o reports whether the window, including the bit being
// sampled right now, equals the sync pattern. The window fills from
// all-zeros, so overlapping prefixes of the pattern are still found.
module sipo_sync_detect #(
    parameter int                  SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic bit_i,
    output logic match_o
);

    logic [SYNC_LEN-1:0] hist_q;
    logic [SYNC_LEN-1:0] hist_d;

    assign hist_d  = (hist_q << 1) | {{(SYNC_LEN-1){1'b0}}, bit_i};
    assign match_o = en_i && (hist_d == SYNC_PATTERN);

    // History window: clear wins over shift so a detected sync starts afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
        end else if (en_i) begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/sipo_frame_capture.sv
// Serial frame capture: hunts for a sync pattern in the serial stream,
// then deserializes the next WIDTH bits into data_out with a one-cycle
// data_valid strobe and a wrapping 4-bit frame counter.
// Optional build macro PARITY_CHECK_EN adds one trailing even-parity bit
// per frame; a failing frame is dropped and flagged on parity_err.
//
// state  | meaning
// -------+--------------------------------------------------------------
// HUNT   | sliding-window search for the sync pattern
// SHIFT  | deserializing WIDTH data bits, bit order latched at sync time
// PARITY | sampling the even-parity bit (PARITY_CHECK_EN builds only)
module sipo_frame_capture
    import sipo_capture_pkg::*;
#(
    parameter int                  WIDTH        = 8,
    parameter int                  SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   serial_in,
    input  logic                   msb_first,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_valid,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   parity_err
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e                  state_q;
    logic [WIDTH-1:0]        sh_q;
    logic [WIDTH-1:0]        sh_d;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    msb_q;
    logic [WIDTH-1:0]        data_out_q;
    logic                    data_valid_q;
    logic                    busy_q;
    logic [FRAME_CNT_W-1:0]  frame_count_q;
    logic                    parity_err_q;
    logic                    sync_en;
    logic                    sync_clr;
    logic                    sync_match;

    // History only advances while hunting; it is held at zero for the
    // whole frame so data bits never contribute to the next sync search.
    assign sync_en  = ena && (state_q == HUNT);
    assign sync_clr = ena && (sync_match || (state_q != HUNT));

    sipo_sync_detect #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (sync_en),
        .clr_i   (sync_clr),
        .bit_i   (serial_in),
        .match_o (sync_match)
    );

    // Next shift-register value including the bit sampled this cycle.
    always_comb begin
        sh_d = sh_q;
        if (msb_q) begin
            sh_d = {sh_q[WIDTH-2:0], serial_in};
        end else begin
            sh_d = {serial_in, sh_q[WIDTH-1:1]};
        end
    end

    // Frame FSM, deserializer and output registers. The strobes clear on
    // every edge, so they stay one cycle wide even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sh_q          <= '0;
            bit_cnt_q     <= '0;
            msb_q         <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            parity_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            if (ena) begin
                case (state_q)
                    HUNT: begin
                        if (sync_match) begin
                            state_q   <= SHIFT;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            msb_q     <= msb_first;
                        end
                    end
                    SHIFT: begin
                        sh_q      <= sh_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef PARITY_CHECK_EN
                            state_q   <= PARITY;
`else
                            data_out_q    <= sh_d;
                            data_valid_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 1'b1;
                            state_q       <= HUNT;
                            busy_q        <= 1'b0;
`endif
                        end
                    end
                    PARITY: begin
`ifdef PARITY_CHECK_EN
                        if (^{sh_q, serial_in} == 1'b0) begin
                            data_out_q    <= sh_q;
                            data_valid_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 1'b1;
                        end else begin
                            parity_err_q  <= 1'b1;
                        end
`endif
                        state_q <= HUNT;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= HUNT;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_sipo_frame_capture.sv
// Bench for sipo_frame_capture: directed scenarios plus a random stream,
// every cycle compared against a queue-based reference model.
module tb_sipo_frame_capture;

    localparam int                  WIDTH    = 8;
    localparam int                  SYNC_LEN = 4;
    localparam logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             serial_in;
    logic             msb_first;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic [3:0]       frame_count;
    logic             parity_err;

    int n_chk   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int n_perr  = 0;

    always #5 clk = ~clk;

    sipo_frame_capture #(
        .WIDTH        (WIDTH),
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .serial_in   (serial_in),
        .msb_first   (msb_first),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .frame_count (frame_count),
        .parity_err  (parity_err)
    );

    // reference model: 0 = hunting, 1 = collecting data, 2 = parity bit
    int               m_mode;
    bit               m_hist[$];
    bit               m_bits[$];
    bit               m_msb;
    logic [WIDTH-1:0] m_word;
    bit               m_valid;
    bit               m_perr;
    logic [3:0]       m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_clear_hist();
        m_hist.delete();
        for (int i = 0; i < SYNC_LEN; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_bits.delete();
        m_msb   = 1'b0;
        m_word  = '0;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        m_fc    = 4'd0;
        m_clear_hist();
    endfunction

    function automatic void m_complete();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m_msb) w[WIDTH-1-i] = m_bits[i];
            else       w[i]         = m_bits[i];
        end
        m_word  = w;
        m_valid = 1'b1;
        m_fc    = m_fc + 4'd1;
        m_mode  = 0;
        m_clear_hist();
    endfunction

    function automatic void model_step(input bit e, input bit b, input bit msb);
        bit ok;
        int ones;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        if (!e) return;
        case (m_mode)
            0: begin
                m_hist.push_back(b);
                m_hist.delete(0);
                ok = 1'b1;
                for (int i = 0; i < SYNC_LEN; i++)
                    if (m_hist[i] != SYNC_PAT[SYNC_LEN-1-i]) ok = 1'b0;
                if (ok) begin
                    m_mode = 1;
                    m_bits.delete();
                    m_msb  = msb;
                    m_clear_hist();
                end
            end
            1: begin
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
`ifdef PARITY_CHECK_EN
                    m_mode = 2;
`else
                    m_complete();
`endif
                end
            end
            default: begin
                ones = int'(b);
                foreach (m_bits[i]) ones += int'(m_bits[i]);
                if (ones % 2 == 0) begin
                    m_complete();
                end else begin
                    m_perr = 1'b1;
                    m_mode = 0;
                    m_clear_hist();
                end
            end
        endcase
    endfunction

    task automatic cycle(input bit e, input bit b, input bit msb);
        ena       = e;
        serial_in = b;
        msb_first = msb;
        @(posedge clk);
        model_step(e, b, msb);
        #1;
        if (data_valid === 1'b1) n_valid++;
        if (parity_err === 1'b1) n_perr++;
        chk("data_valid",  32'(data_valid),  32'(m_valid));
        chk("busy",        32'(busy),        32'(m_mode != 0));
        chk("data_out",    32'(data_out),    32'(m_word));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("parity_err",  32'(parity_err),  32'(m_perr));
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit msb);
        logic [31:0] vv;
        vv = v;
        for (int i = 0; i < n; i++) cycle(1'b1, vv[n-1-i], msb);
    endtask

    task automatic send_data(input logic [WIDTH-1:0] w, input bit msb);
        for (int i = 0; i < WIDTH; i++) cycle(1'b1, msb ? w[WIDTH-1-i] : w[i], msb);
`ifdef PARITY_CHECK_EN
        cycle(1'b1, ^w, msb);
`endif
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit msb);
        send_bits(32'(SYNC_PAT), SYNC_LEN, msb);
        send_data(w, msb);
    endtask

    // async reset asserted between edges; outputs must clear before the next edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_data_out",    32'(data_out),    32'h0);
        chk("rst_data_valid",  32'(data_valid),  32'h0);
        chk("rst_busy",        32'(busy),        32'h0);
        chk("rst_frame_count", 32'(frame_count), 32'h0);
        chk("rst_parity_err",  32'(parity_err),  32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w;
        rst_n     = 1'b1;
        ena       = 1'b0;
        serial_in = 1'b0;
        msb_first = 1'b1;
        model_reset();
        do_reset();

        // basic MSB-first frame
        send_frame(8'hA5, 1'b1);
        chk("a5_word", 32'(data_out), 32'hA5);
        chk("a5_fc",   32'(frame_count), 32'd1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);

        // LSB-first frame with msb_first toggling during the data bits
        send_bits(32'(SYNC_PAT), SYNC_LEN, 1'b0);
        w = 8'h12;
        for (int i = 0; i < WIDTH; i++) cycle(1'b1, w[i], (i % 2) == 1);
`ifdef PARITY_CHECK_EN
        cycle(1'b1, ^w, 1'b1);
`endif
        chk("lsb_word", 32'(data_out), 32'h12);

        // overlapping sync prefix: 1,0,1,0,1,1 detects on the 6th bit
        send_bits(32'b10101, 5, 1'b1);
        chk("slide_not_yet", 32'(busy), 32'd0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("slide_busy", 32'(busy), 32'd1);
        send_data(8'hA5, 1'b1);
        chk("slide_word", 32'(data_out), 32'hA5);

        // non-matching stream
        send_bits(32'b10011, 5, 1'b1);
        chk("nodetect_busy", 32'(busy), 32'd0);

        // ena low for three cycles in the middle of a frame
        send_frame(8'h3C, 1'b1);
        n_valid = 0;
        send_bits(32'(SYNC_PAT), SYNC_LEN, 1'b1);
        send_bits(32'b1010, 4, 1'b1);
        for (int j = 0; j < 3; j++) cycle(1'b0, (j % 2) == 0, 1'b1);
        send_bits(32'b0101, 4, 1'b1);
`ifdef PARITY_CHECK_EN
        cycle(1'b1, 1'b0, 1'b1);
`endif
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("ena_word",   32'(data_out), 32'hA5);
        chk("ena_pulses", 32'(n_valid),  32'd1);

        // reset mid-frame discards the partial word
        send_bits(32'(SYNC_PAT), SYNC_LEN, 1'b1);
        send_bits(32'b1100, 4, 1'b1);
        do_reset();
        n_valid = 0;
        send_frame(8'h5A, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("rst_frame_pulses", 32'(n_valid),     32'd1);
        chk("rst_frame_word",   32'(data_out),    32'h5A);
        chk("rst_frame_fc",     32'(frame_count), 32'd1);

        // 17 back-to-back frames wrap the counter to 1
        do_reset();
        for (int f = 0; f < 17; f++) send_frame(WIDTH'($urandom), 1'($urandom));
        chk("wrap_fc", 32'(frame_count), 32'd1);

`ifdef PARITY_CHECK_EN
        send_frame(8'h5A, 1'b1);
        n_perr = 0;
        send_bits(32'(SYNC_PAT), SYNC_LEN, 1'b1);
        w = 8'hA5;
        for (int i = 0; i < WIDTH; i++) cycle(1'b1, w[WIDTH-1-i], 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("perr_pulse", 32'(n_perr),   32'd1);
        chk("perr_hold",  32'(data_out), 32'h5A);
`endif

        // random stream
        for (int k = 0; k < 3000; k++)
            cycle($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sipo_frame_capture.md
Name: sipo_frame_capture

Overview:
Downstream consumer of the serial shift-register stage: takes its 1-bit serial output and hunts for a fixed sync pattern. It then deserializes the next WIDTH bits into a parallel word. Each completed word is presented with a one-cycle valid strobe and a wrapping frame counter, sized to drive the uo_out pins.

Parameters:
WIDTH, 8, data bits per frame (2..16)
SYNC_LEN, 4, sync pattern length in bits (2..8)
SYNC_PATTERN, 4'b1011, sync word [SYNC_LEN-1:0], first-received bit is MSB

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; low freezes all state
serial_in  input  1  serial bit stream, one bit per enabled cycle
msb_first  input  1  1: first data bit is word MSB; 0: first data bit is LSB
data_out  output  WIDTH  last captured word, held until next capture
data_valid  output  1  one-cycle pulse when data_out updates
busy  output  1  high while a frame is being shifted (state != HUNT)
frame_count  output  4  completed-frame counter, wraps 15->0
parity_err  output  1  one-cycle pulse on parity failure (0 without feature)

Behaviour:
- Reset (async, rst_n=0): state=HUNT, history=0, shift reg=0, bit_cnt=0, data_out=0, data_valid=0, frame_count=0, parity_err=0, busy=0.
- ena=0: no register changes; data_valid and parity_err forced 0 in that cycle; frame resumes when ena returns.
- HUNT: each enabled edge, history <= {history[SYNC_LEN-2:0], serial_in}. The window is sliding, so overlapping prefixes are found.
  - If the updated value equals SYNC_PATTERN: go to SHIFT, clear history and bit_cnt, latch msb_first into msb_q.
- SHIFT: each enabled edge samples serial_in.
  - msb_q=1: sh <= {sh[WIDTH-2:0], bit}.
  - msb_q=0: sh <= {bit, sh[WIDTH-1:1]}.
  - bit_cnt increments.
  - On the edge sampling bit WIDTH-1:
    - data_out <= completed word, including the current bit.
    - data_valid <= 1 for exactly one cycle.
    - frame_count <= frame_count+1 (mod 16).
    - return to HUNT with history cleared.
- Latency: data_valid is high in the cycle after the edge that sampled the last data bit.
- A new sync may begin on the cycle immediately after the last data bit. Bits received during SHIFT never feed sync detection.
- msb_first changes mid-frame are ignored; the latched msb_q governs the frame.
- rst_n asserted mid-frame discards the partial word immediately and outputs return to reset values.
- busy = (state != HUNT), registered with the state.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - After the last data bit, FSM enters PARITY and samples one even-parity bit.
  - If ^{word, parity_bit}==0: data_out/data_valid/frame_count update as above.
  - Otherwise: data_out holds its old value, no valid pulse, parity_err pulses one cycle, frame_count unchanged.
  - Returns to HUNT in both cases.
  - Latency grows by one bit.
- Not defined: no PARITY state; parity_err tied 0. The port list is identical in both builds.

Decomposition:
- Package sipo_capture_pkg:
  - state enum typedef {HUNT, SHIFT, PARITY}.
  - default SYNC_PATTERN/SYNC_LEN constants.
  - frame_count width constant (4).
- Sub-module sipo_sync_detect: history shift register plus compare, with clear and enable inputs, and a 1-bit match output.
- The top holds the FSM, the deserializer and the output registers.

Test Plan:
- Reset: drive rst_n=0 mid-stream -> data_out=0x00, data_valid=0, busy=0, frame_count=0, asynchronously before the next clk edge.
- Sync 1,0,1,1 then msb_first=1 bits 1,0,1,0,0,1,0,1 -> busy high during data, data_valid one cycle after 8th bit, data_out=0xA5, frame_count=1.
- msb_first=0, sync then bits 0,1,0,0,1,0,0,0 -> data_out=0x12. Toggling msb_first mid-frame still yields 0x12.
- Sliding sync: 1,0,1,0,1,1 then 0xA5 MSB-first -> sync detected on the 6th bit, data_out=0xA5. The stream 1,0,0,1,1 alone -> no detect, busy=0.
- ena=0 for 3 cycles after 4th data bit with serial_in toggling -> those bits ignored, final data_out=0xA5, exactly one valid pulse. Also: rst_n pulse after 4 data bits, then a full frame -> only the second frame is reported.
- 17 back-to-back frames -> frame_count wraps to 1. With PARITY_CHECK_EN: 0xA5 + parity 0 -> valid. 0xA5 + parity 1 -> parity_err pulse, data_out unchanged.
